// File: rtl/systolic_mac_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: clears the array,
// issues skewed operand-buffer reads, waits out propagation, then drains result rows.
module systolic_mac_ctrl #(
    parameter int N     = 4,
    parameter int K_MAX = 64,
    parameter int AW    = $clog2(K_MAX),
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int TW    = $clog2(K_MAX + 2 * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [KW-1:0]          k_len,
    output logic                   cmd_err,
    output logic                   busy,
    output logic                   array_clear,
    output logic [N-1:0]           a_lane_en,
    output logic [N*AW-1:0]        a_rd_addr,
    output logic [N-1:0]           b_lane_en,
    output logic [N*AW-1:0]        b_rd_addr,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [$clog2(N)-1:0]   res_row_sel,
    output logic                   done
);
    localparam int CW = TW + 1;
    localparam int RW = $clog2(N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

    state_t         state;
    logic [KW-1:0]  k_reg;
    logic [TW-1:0]  t;
    logic [TW-1:0]  feed_last;
    logic [TW-1:0]  t_next;
    logic           k_ok;

    assign feed_last = TW'(k_reg) + TW'(N - 2);
    assign t_next    = t + TW'(1);
    assign k_ok      = (k_len != '0) && (k_len <= KW'(K_MAX));

    // Lane i is live for k_len consecutive steps starting at step i (the skew).
    function automatic logic [N-1:0] lane_en_at(input logic [TW-1:0] tv, input logic [KW-1:0] kv);
        logic [N-1:0] en;
        en = '0;
        for (int i = 0; i < N; i++)
            en[i] = (CW'(tv) >= CW'(i)) && (CW'(tv) < CW'(i) + CW'(kv));
        return en;
    endfunction

    function automatic logic [N*AW-1:0] lane_addr_at(input logic [TW-1:0] tv, input logic [KW-1:0] kv);
        logic [N-1:0]    en;
        logic [N*AW-1:0] addr;
        en   = lane_en_at(tv, kv);
        addr = '0;
        for (int i = 0; i < N; i++)
            if (en[i]) addr[i*AW +: AW] = AW'(CW'(tv) - CW'(i));
        return addr;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            k_reg       <= '0;
            t           <= '0;
            start_ready <= 1'b1;
            cmd_err     <= 1'b0;
            busy        <= 1'b0;
            array_clear <= 1'b0;
            a_lane_en   <= '0;
            a_rd_addr   <= '0;
            b_lane_en   <= '0;
            b_rd_addr   <= '0;
            res_valid   <= 1'b0;
            res_row_sel <= '0;
            done        <= 1'b0;
        end else begin
            cmd_err     <= 1'b0;
            done        <= 1'b0;
            array_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        if (k_ok) begin
                            k_reg       <= k_len;
                            state       <= CLEAR;
                            start_ready <= 1'b0;
                            busy        <= 1'b1;
                            array_clear <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state     <= FEED;
                    t         <= '0;
                    a_lane_en <= lane_en_at('0, k_reg);
                    a_rd_addr <= lane_addr_at('0, k_reg);
                    b_lane_en <= lane_en_at('0, k_reg);
                    b_rd_addr <= lane_addr_at('0, k_reg);
                end
                FEED: begin
                    if (t == feed_last) begin
                        state     <= FLUSH;
                        t         <= '0;
                        a_lane_en <= '0;
                        a_rd_addr <= '0;
                        b_lane_en <= '0;
                        b_rd_addr <= '0;
                    end else begin
                        t         <= t_next;
                        a_lane_en <= lane_en_at(t_next, k_reg);
                        a_rd_addr <= lane_addr_at(t_next, k_reg);
                        b_lane_en <= lane_en_at(t_next, k_reg);
                        b_rd_addr <= lane_addr_at(t_next, k_reg);
                    end
                end
                FLUSH: begin
                    // One read-latency cycle plus N-1 hops to reach the far corner PE.
                    if (t == TW'(N - 1)) begin
                        state       <= DRAIN;
                        t           <= '0;
                        res_valid   <= 1'b1;
                        res_row_sel <= '0;
                    end else begin
                        t <= t_next;
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (res_row_sel == RW'(N - 1)) begin
                            state       <= IDLE;
                            res_valid   <= 1'b0;
                            res_row_sel <= '0;
                            busy        <= 1'b0;
                            start_ready <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            res_row_sel <= res_row_sel + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_mac_ctrl.sv
// Directed bench for systolic_mac_ctrl with a small behavioural PE array and operand buffers.
`timescale 1ns/1ps
module tb_systolic_mac_ctrl;
    localparam int N     = 4;
    localparam int K_MAX = 64;
    localparam int AW    = $clog2(K_MAX);
    localparam int KW    = $clog2(K_MAX + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start_valid;
    logic              start_ready;
    logic [KW-1:0]     k_len;
    logic              cmd_err;
    logic              busy;
    logic              array_clear;
    logic [N-1:0]      a_lane_en;
    logic [N*AW-1:0]   a_rd_addr;
    logic [N-1:0]      b_lane_en;
    logic [N*AW-1:0]   b_rd_addr;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_row_sel;
    logic              done;

    always #5 clk = ~clk;

    systolic_mac_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready), .k_len(k_len),
        .cmd_err(cmd_err), .busy(busy), .array_clear(array_clear),
        .a_lane_en(a_lane_en), .a_rd_addr(a_rd_addr),
        .b_lane_en(b_lane_en), .b_rd_addr(b_rd_addr),
        .res_valid(res_valid), .res_ready(res_ready), .res_row_sel(res_row_sel),
        .done(done)
    );

    // Operand buffers (1-cycle latency) feeding an output-stationary PE grid.
    int a_mem [N][K_MAX];
    int b_mem [N][K_MAX];
    int a_data [N];
    int b_data [N];
    int a_r [N][N];
    int b_r [N][N];
    int a_in [N][N];
    int b_in [N][N];
    int acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_in[i][j] = (j == 0) ? a_data[i] : a_r[i][(j == 0) ? 0 : j - 1];
                b_in[i][j] = (i == 0) ? b_data[j] : b_r[(i == 0) ? 0 : i - 1][j];
            end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            a_data[i] <= a_lane_en[i] ? a_mem[i][a_rd_addr[i*AW +: AW]] : 0;
            b_data[i] <= b_lane_en[i] ? b_mem[i][b_rd_addr[i*AW +: AW]] : 0;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (array_clear) begin
                    acc[i][j] <= 0;
                    a_r[i][j] <= 0;
                    b_r[i][j] <= 0;
                end else begin
                    acc[i][j] <= acc[i][j] + a_in[i][j] * b_in[i][j];
                    a_r[i][j] <= a_in[i][j];
                    b_r[i][j] <= b_in[i][j];
                end
            end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " start_ready"}, 32'(start_ready), 32'd1);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " res_valid"},   32'(res_valid),   32'd0);
        check({tag, " done"},        32'(done),        32'd0);
        check({tag, " cmd_err"},     32'(cmd_err),     32'd0);
        check({tag, " array_clear"}, 32'(array_clear), 32'd0);
        check({tag, " a_lane_en"},   32'(a_lane_en),   32'd0);
        check({tag, " b_lane_en"},   32'(b_lane_en),   32'd0);
    endtask

    // Counts cycles from the accept edge to the first res_valid.
    task automatic run_to_drain(input logic [KW-1:0] kk, input int exp_lat, input string tag);
        int cyc;
        start_valid = 1'b1;
        k_len       = kk;
        cyc         = 0;
        do begin
            tick();
            start_valid = 1'b0;
            cyc++;
        end while (!res_valid && cyc < 200);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    // With A = identity, row r of the result is B row r when r < k, else zero.
    task automatic drain(input int kk, input bit stall, input string tag);
        res_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            check($sformatf("%s row_sel r%0d", tag, r), 32'(res_row_sel), 32'(r));
            check($sformatf("%s res_valid r%0d", tag, r), 32'(res_valid), 32'd1);
            for (int j = 0; j < N; j++)
                check($sformatf("%s data r%0d c%0d", tag, r, j), 32'(acc[res_row_sel][j]),
                      32'((r < kk) ? (r * 4 + j + 1) : 0));
            if (stall && r == 1) begin
                res_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check({tag, " stall row_sel"},   32'(res_row_sel), 32'd1);
                    check({tag, " stall res_valid"}, 32'(res_valid),   32'd1);
                    check({tag, " stall done"},      32'(done),        32'd0);
                end
                res_ready = 1'b1;
            end
            check($sformatf("%s no early done r%0d", tag, r), 32'(done), 32'd0);
            tick();
        end
        res_ready = 1'b0;
        check({tag, " done pulse"},  32'(done),        32'd1);
        check({tag, " busy off"},    32'(busy),        32'd0);
        check({tag, " valid off"},   32'(res_valid),   32'd0);
        check({tag, " start_ready"}, 32'(start_ready), 32'd1);
    endtask

    logic [N-1:0] exp_en [6];

    initial begin
        exp_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++) begin
                a_mem[i][k] = (i == k) ? 1 : 0;
                b_mem[i][k] = (k < N) ? (k * 4 + i + 1) : 0;
            end
        reset       = 1'b0;
        start_valid = 1'b0;
        k_len       = '0;
        res_ready   = 1'b0;
        tick();
        tick();
        check_idle_outputs("in reset");
        reset = 1'b1;
        tick();
        tick();
        check_idle_outputs("after reset");

        // Rejected commands: k_len = 0 and k_len = K_MAX+1
        start_valid = 1'b1;
        k_len       = KW'(0);
        tick();
        check("k0 cmd_err",     32'(cmd_err),     32'd1);
        check("k0 busy",        32'(busy),        32'd0);
        check("k0 array_clear", 32'(array_clear), 32'd0);
        k_len = KW'(K_MAX + 1);
        tick();
        check("k65 cmd_err",     32'(cmd_err),     32'd1);
        check("k65 busy",        32'(busy),        32'd0);
        check("k65 array_clear", 32'(array_clear), 32'd0);
        start_valid = 1'b0;
        tick();
        check("cmd_err one cycle", 32'(cmd_err), 32'd0);
        check("still idle",        32'(busy),    32'd0);

        // k_len = 3, cycle-by-cycle
        start_valid = 1'b1;
        k_len       = KW'(3);
        tick();
        check("k3 array_clear", 32'(array_clear), 32'd1);
        check("k3 busy",        32'(busy),        32'd1);
        check("k3 start_ready", 32'(start_ready), 32'd0);
        k_len = KW'(5);
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("k3 a_en t%0d", c), 32'(a_lane_en), 32'(exp_en[c]));
            check($sformatf("k3 b_en t%0d", c), 32'(b_lane_en), 32'(exp_en[c]));
            check($sformatf("k3 ready held t%0d", c), 32'(start_ready), 32'd0);
            check($sformatf("k3 clear off t%0d", c), 32'(array_clear), 32'd0);
            if (c == 3) begin
                check("k3 t3 a lane3 addr", 32'(a_rd_addr[3*AW +: AW]), 32'd0);
                check("k3 t3 a lane1 addr", 32'(a_rd_addr[1*AW +: AW]), 32'd2);
                check("k3 t3 a_rd_addr",    32'(a_rd_addr), 32'h0000_1080);
                check("k3 t3 b_rd_addr",    32'(b_rd_addr), 32'h0000_1080);
            end
        end
        start_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("k3 flush a_en %0d", c), 32'(a_lane_en), 32'd0);
            check($sformatf("k3 flush valid %0d", c), 32'(res_valid), 32'd0);
        end
        tick();
        check("k3 res_valid at 12", 32'(res_valid), 32'd1);
        drain(3, 1'b0, "k3");
        tick();
        check("k3 done one cycle", 32'(done), 32'd0);
        check("k3 held cmd not taken", 32'(busy), 32'd0);

        // k_len = 4 with a 5-cycle stall on row 1
        run_to_drain(KW'(4), 1 + (4 + N - 1) + N + 1, "k4");
        drain(4, 1'b1, "k4");

        // k_len = K_MAX, then a new command accepted in the done cycle
        tick();
        run_to_drain(KW'(K_MAX), 1 + (K_MAX + N - 1) + N + 1, "k64");
        drain(K_MAX, 1'b0, "k64");
        start_valid = 1'b1;
        k_len       = KW'(2);
        tick();
        start_valid = 1'b0;
        check("b2b array_clear", 32'(array_clear), 32'd1);
        check("b2b done off",    32'(done),        32'd0);
        begin
            int cyc;
            cyc = 1;
            while (!res_valid && cyc < 200) begin
                tick();
                cyc++;
            end
            check("b2b latency", 32'(cyc), 32'(1 + (2 + N - 1) + N + 1));
        end
        drain(2, 1'b0, "k2");

        // Async reset during FEED at t=2
        start_valid = 1'b1;
        k_len       = KW'(3);
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        check("pre-abort a_en t2", 32'(a_lane_en), 32'b0111);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("async abort");
        reset = 1'b1;
        tick();
        run_to_drain(KW'(1), 1 + 4 + 4 + 1, "k1 after abort");
        drain(1, 1'b0, "k1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/systolic_mac_ctrl.md
Name: systolic_mac_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of multiply-accumulate PEs; A operands enter per row, B operands per column, partial sums held in each PE.
- Accepts a command (inner dimension k_len), clears the array, issues skewed per-lane operand-buffer reads, and waits for propagation to finish.
- Then drains the N result rows through a valid/ready handshake.
- Sits between the tile command source and the array + operand buffers; the datapath zeroes operands on disabled lanes.

Parameters:
- N, 4, array dimension (rows = columns = lanes)
- K_MAX, 64, maximum inner dimension per command
- AW, $clog2(K_MAX), operand-buffer address width per lane
- KW, $clog2(K_MAX+1), k_len width
- TW, $clog2(K_MAX+2*N), phase counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start_valid  in  1  command valid
- start_ready  out  1  command accepted when both high
- k_len  in  KW  inner dimension, sampled at accept
- cmd_err  out  1  one-cycle pulse on rejected command
- busy  out  1  high in any state other than IDLE
- array_clear  out  1  synchronous clear to all PEs (accumulators, operand regs)
- a_lane_en  out  N  row i issues an A read this cycle
- a_rd_addr  out  N*AW  packed, lane i at [i*AW +: AW]
- b_lane_en  out  N  column j issues a B read this cycle
- b_rd_addr  out  N*AW  packed, lane j at [j*AW +: AW]
- res_valid  out  1  result row available
- res_ready  in  1  consumer accepts the row
- res_row_sel  out  $clog2(N)  row index the datapath muxes out
- done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (reset=0, async): state=IDLE. All counters 0. All outputs 0 except start_ready=1.
- Operand buffers have 1-cycle read latency. Datapath drives 0 into a lane whose enable was low in the previous cycle.
- IDLE: start_ready=1.
  - Accept with 1 <= k_len <= K_MAX: latch k_len, go to CLEAR.
  - Accept with k_len==0 or k_len>K_MAX: cmd_err=1 for one cycle, remain IDLE.
- Non-IDLE states: start_ready=0; start_valid is ignored.
- CLEAR: 1 cycle, array_clear=1, t<=0, then FEED.
- FEED: k_len+N-1 cycles, t = 0..k_len+N-2.
  - Lane i enabled iff i <= t < i+k_len; addr = t-i.
  - a and b use identical enable/address patterns.
  - Disabled lanes drive addr 0.
  - Last cycle goes to FLUSH with t<=0.
- FLUSH: exactly N cycles (1 read latency + N-1 hops), all lane enables 0. Then DRAIN with row<=0.
- DRAIN:
  - res_valid=1, res_row_sel=row.
  - On res_valid&&res_ready: if row==N-1 go to IDLE and pulse done in the first IDLE cycle; else row<=row+1.
  - res_ready low holds row and res_valid unchanged indefinitely.
  - Lanes stay disabled, so PE sums are stable.
- done and start acceptance may coincide (IDLE cycle); a new command accepted then proceeds normally.
- Reset asserted mid-operation aborts immediately to IDLE. No done pulse; partial PE state is don't-care (next CLEAR wipes it).
- Total command latency, accept to first res_valid: 1 + (k_len+N-1) + N + 1 cycles (the accept edge moves to CLEAR).

Test Plan:
- Reset release, no stimulus -> start_ready=1; busy, res_valid, done, cmd_err, array_clear, lane enables all 0.
- N=4, k_len=3 accepted at cycle 0:
  - Cycle 1: array_clear=1.
  - FEED cycles 2..7: a_lane_en = 0001, 0011, 0111, 1110, 1100, 1000.
  - At t=3, lane3 addr=0 and lane1 addr=2.
  - FLUSH cycles 8..11, res_valid first high at cycle 12.
- Same run with identity A and B = [1..16] loaded in the buffers -> rows drained in order 0..3 with res_row_sel 0,1,2,3; done pulses once after row 3.
- res_ready held low 5 cycles during row 1 -> res_row_sel stays 1, res_valid stays 1, no done pulse.
- k_len=0, then k_len=K_MAX+1=65 -> cmd_err pulses each time, busy stays 0, no array_clear.
- start_valid held high during FEED -> start_ready=0, command not taken.
- Async reset during FEED at t=2 -> outputs return to reset values without a clock edge; new k_len=1 command completes in 1+4+4+1 cycles to res_valid.
